mult8_error_accumulator: RTL

Streaming error-metric stage that sits directly downstream of the evolved approximate 8-bit multipliers in the GA evaluation flow. It consumes operand pairs together with the approximate product the candidate produced. It computes the exact product internally and accumulates the error statistics the fitness function needs over a programmed number of samples: sum of error distance, maximum error distance, and erroneous-sample count. It reports them with a one-cycle done pulse.

---
 rtl/mult_eval_pkg.sv | 20 ++
 rtl/exact_ed8.sv | 19 +
 rtl/mult8_error_accumulator.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_eval_pkg.sv
// Shared types and widths for the approximate-multiplier evaluation blocks.
package mult_eval_pkg;

    localparam int unsigned OPW = 8;
    localparam int unsigned PW  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [PW-1:0]  p;
    } sample_t;

endpackage

// File: rtl/exact_ed8.sv
// Combinational exact 8x8 unsigned product and its absolute distance to a
// candidate product.
module exact_ed8
    import mult_eval_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic [PW-1:0]  p,
    output logic [PW-1:0]  ed_c
);

    logic [PW-1:0] exact;

    always_comb begin
        exact = PW'(a) * PW'(b);
        ed_c  = (exact >= p) ? (exact - p) : (p - exact);
    end

endmodule

// File: rtl/mult8_error_accumulator.sv
// Accumulates error distance statistics of an approximate 8-bit multiplier
// over a programmed number of samples; three-stage pipeline plus run FSM.
module mult8_error_accumulator
    import mult_eval_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic [PW-1:0]    in_p,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_ed,
    output logic [PW-1:0]    max_ed,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] num_q, num_nx;
    logic [CNT_W-1:0] acc_cnt, acc_cnt_nx;
    logic             in_ready_nx, busy_nx, done_nx;
    logic             clear_c, accept_c, pipe_empty_c;

    sample_t          s1;
    logic             s1_valid;
    logic [PW-1:0]    ed_c;
    logic [PW-1:0]    s2_ed;
    logic             s2_mis, s2_valid;
    logic [ACC_W:0]   sum_wide_c;

    assign accept_c     = in_valid & in_ready;
    assign pipe_empty_c = ~s1_valid & ~s2_valid;

    // Next-state and next-value logic for the run controller.
    always_comb begin
        state_nx   = state;
        num_nx     = num_q;
        acc_cnt_nx = acc_cnt;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = RUN;
                    num_nx     = num_samples;
                    acc_cnt_nx = '0;
                    clear_c    = 1'b1;
                end
            end
            RUN: begin
                acc_cnt_nx = acc_cnt + CNT_W'(accept_c);
                if (acc_cnt_nx == num_q) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty_c) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        in_ready_nx = (state_nx == RUN) && (acc_cnt_nx < num_nx);
        busy_nx     = (state_nx == RUN) || (state_nx == DRAIN);
        done_nx     = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            num_q    <= '0;
            acc_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            num_q    <= num_nx;
            acc_cnt  <= acc_cnt_nx;
            in_ready <= in_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // S1: capture accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1 <= '{a: in_a, b: in_b, p: in_p};
            end
        end
    end

    exact_ed8 u_exact_ed8 (
        .a    (s1.a),
        .b    (s1.b),
        .p    (s1.p),
        .ed_c (ed_c)
    );

    // S2: register error distance and mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ed    <= '0;
            s2_mis   <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed  <= ed_c;
                s2_mis <= (ed_c != '0);
            end
        end
    end

    // One extra bit catches the carry that signals saturation.
    assign sum_wide_c = {1'b0, sum_ed} + (ACC_W+1)'(s2_ed);

    // S3: accumulators, cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ed       <= '0;
            max_ed       <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else if (clear_c) begin
            sum_ed       <= '0;
            max_ed       <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else if (s2_valid) begin
            sum_ed       <= sum_wide_c[ACC_W] ? '1 : sum_wide_c[ACC_W-1:0];
            if (s2_ed > max_ed) begin
                max_ed <= s2_ed;
            end
            err_count    <= err_count + CNT_W'(s2_mis);
            sample_count <= sample_count + CNT_W'(1);
        end
    end

endmodule
